// File: rtl/frame_loader.sv
// frame_loader: accepts an RGB pixel stream over a valid/ready handshake, applies a global
// brightness scale, reorders to GRB and writes each pixel into the shared frame-buffer BRAM.
// After a frame's last pixel the pixel count is written to word 0.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   s_tdata/s_tvalid/     pixel stream, R[23:16] G[15:8] B[7:0], s_tlast marks the last pixel
//   s_tready/s_tlast
//   brightness            global scale, sampled on each accepted beat
//   addr/din/en/web       registered BRAM write port
//   frame_done            one-cycle pulse coincident with the count write
//   overflow              current/last frame exceeded MAX_PIXELS
module frame_loader #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned PIXEL_OFFSET = 4,
  parameter int unsigned MAX_PIXELS   = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [23:0]           s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [7:0]            brightness,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] din,
  output logic                  en,
  output logic [3:0]            web,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int unsigned IdxW = $clog2(MAX_PIXELS + 1);
  localparam logic [IdxW-1:0] MaxIdx = IdxW'(MAX_PIXELS);

  typedef enum logic [1:0] {StAccept, StCommit, StDone} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] din_q, din_d;
  logic                  en_q, en_d;
  logic [3:0]            web_q, web_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overflow_q, overflow_d;

  logic       hs;
  logic [8:0] gain;
  logic [7:0] r_s, g_s, b_s;

  // c * (brightness + 1) >> 8: brightness 255 is identity, 0 is black.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [8:0] k);
    logic [16:0] p;
    p = {9'b0, c} * {8'b0, k};
    return p[15:8];
  endfunction

  assign s_tready = (state_q == StAccept) && !reset;
  assign hs       = s_tvalid && s_tready;
  assign gain     = {1'b0, brightness} + 9'd1;
  assign r_s      = scale(s_tdata[23:16], gain);
  assign g_s      = scale(s_tdata[15:8], gain);
  assign b_s      = scale(s_tdata[7:0], gain);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    din_d        = din_q;
    en_d         = 1'b0;
    web_d        = 4'h0;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    unique case (state_q)
      StAccept: begin
        if (hs) begin
          // First beat of a frame clears the previous frame's overflow flag.
          if (idx_q == '0) overflow_d = 1'b0;
          if (idx_q < MaxIdx) begin
            addr_d = ADDR_WIDTH'(PIXEL_OFFSET) * (ADDR_WIDTH'(idx_q) + ADDR_WIDTH'(1));
            din_d  = ADDR_WIDTH'({g_s, r_s, b_s});
            en_d   = 1'b1;
            web_d  = 4'hF;
            idx_d  = idx_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
          if (s_tlast) state_d = StCommit;
        end
      end
      StCommit: begin
        // idx saturates at MAX_PIXELS, so it already is min(idx, MAX_PIXELS).
        addr_d       = '0;
        din_d        = ADDR_WIDTH'(idx_q);
        en_d         = 1'b1;
        web_d        = 4'hF;
        frame_done_d = 1'b1;
        state_d      = StDone;
      end
      StDone: begin
        idx_d   = '0;
        state_d = StAccept;
      end
      default: state_d = StAccept;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StAccept;
      idx_q        <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      en_q         <= 1'b0;
      web_q        <= 4'h0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      en_q         <= en_d;
      web_q        <= web_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign addr       = addr_q;
  assign din        = din_q;
  assign en         = en_q;
  assign web        = web_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule
